// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill count, threshold flags,
// sticky overflow/underflow errors and selectable registered or FWFT read data.
module sync_fifo_flags #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);
  localparam logic [ASIZE:0] ONE = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] AF  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AE  = (ASIZE+1)'(AEMPTY_TH);
  logic [DSIZE-1:0] mem_q [2**ASIZE];
  logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, wr_en, rd_en;
  logic [DSIZE-1:0] head;
  assign rempty        = wptr_q == rptr_q;
  assign wfull         = (wptr_q[ASIZE] != rptr_q[ASIZE]) && (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
  assign walmost_full  = count_q >= AF;
  assign ralmost_empty = count_q <= AE;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign head          = mem_q[rptr_q[ASIZE-1:0]];
  always_comb begin
    wr_en   = winc && !wfull;
    rd_en   = rinc && !rempty;
    wptr_d  = wr_en ? wptr_q + ONE : wptr_q;
    rptr_d  = rd_en ? rptr_q + ONE : rptr_q;
    count_d = (wr_en && !rd_en) ? count_q + ONE : (rd_en && !wr_en) ? count_q - ONE : count_q;
    ovf_d   = (winc && wfull) || (ovf_q && !err_clr);
    udf_d   = (rinc && rempty) || (udf_q && !err_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
  end
  // FWFT masks the head with empty so rdata reads 0 out of reset rather than stale memory
  if (FWFT != 0) begin : g_fwft
    assign rdata = rempty ? '0 : head;
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q, rdata_d;
    assign rdata_d = rd_en ? head : rdata_q;
    assign rdata   = rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: random and directed stimulus against a queue model, registered and FWFT instances side by side.
module tb_sync_fifo_flags;
  logic clk = 1'b0, rst_n = 1'b0, winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata0, rdata1;
  logic [3:0] count0, count1;
  logic wfull0, rempty0, af0, ae0, ovf0, udf0;
  logic wfull1, rempty1, af1, ae1, ovf1, udf1;
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] last = 8'h00;
  logic ovf = 1'b0, udf = 1'b0, fire = 1'b0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata0),
    .wfull(wfull0), .rempty(rempty0), .walmost_full(af0), .ralmost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0), .err_clr(err_clr));

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata1),
    .wfull(wfull1), .rempty(rempty1), .walmost_full(af1), .ralmost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1), .err_clr(err_clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_vec();
    int n;
    n = mq.size();
    return 32'({4'(n), n == 8, n == 0, n >= 6, n <= 2, ovf, udf});
  endfunction

  task automatic check_state(input string tag);
    chk({tag, " cnt/flags reg"}, 32'({count0, wfull0, rempty0, af0, ae0, ovf0, udf0}), exp_vec());
    chk({tag, " cnt/flags fwft"}, 32'({count1, wfull1, rempty1, af1, ae1, ovf1, udf1}), exp_vec());
    chk({tag, " rdata reg"}, 32'(rdata0), 32'(last));
  endtask

  // One clock of stimulus; the model applies the acceptance rules on pre-edge occupancy
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic full, empty, rok, wok;
    winc = w; wdata = d; rinc = r; err_clr = c;
    full  = mq.size() == 8;
    empty = mq.size() == 0;
    rok   = r && !empty;
    wok   = w && !full;
    if (rok) sb.push_back(mq[0]);
    @(posedge clk);
    if (rok) last = mq.pop_front();
    if (wok) mq.push_back(d);
    ovf = (w && full) || (ovf && !c);
    udf = (r && empty) || (udf && !c);
    #1 check_state("step");
  endtask

  always @(negedge clk) begin
    if (!rst_n) fire = 1'b0;
    else begin
      if (fire) begin
        if (sb.size() == 0) chk("scoreboard underrun", 32'd1, 32'd0);
        else chk("read data order", 32'(rdata0), 32'(sb.pop_front()));
      end
      chk("fwft head", 32'(rdata1), 32'(mq.size() != 0 ? mq[0] : 8'h00));
      fire = rinc && !rempty0;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check_state("reset");
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("overflow held over clear", 32'(ovf0), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("last drained word", 32'(rdata0), 32'h88);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("simul at empty count", 32'(count0), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("simul at 4 count", 32'(count0), 32'd4);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("simul at full count", 32'(count0), 32'd7);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft first word", 32'({rempty1, rdata1}), 32'h0A5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    while (mq.size() != 5) step(mq.size() < 5, 8'($urandom), mq.size() > 5, 1'b0);
    winc = 1'b1; wdata = 8'h3C; rinc = 1'b0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    mq.delete(); sb.delete();
    last = 8'h00; ovf = 1'b0; udf = 1'b0;
    #1 check_state("async reset");
    chk("fwft rdata in reset", 32'(rdata1), 32'd0);
    winc = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_state("after reset");
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    while (mq.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
